// File: rtl/mux_pkg.sv
// Channel encodings shared by the 2-to-1 mux and the 1-to-2 buffered demux.
package mux_pkg;

  typedef enum logic {
    CH_0 = 1'b0,
    CH_1 = 1'b1
  } chan_e;

endpackage

// File: rtl/demux_chan_fifo.sv
// Per-channel FIFO for the buffered demux: registered storage, wrapping pointers,
// occupancy count and full/empty flags. Head data reads 0 while empty.
module demux_chan_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage is left unreset; the empty gate below keeps stale entries invisible.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/demux_1_to_2_buffered.sv
// Routes one valid/ready stream to one of two buffered output channels by a
// per-beat select bit, with a wrapping accepted-beat counter per channel.
module demux_1_to_2_buffered
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_0_data,
  output logic             out_0_valid,
  input  logic             out_0_ready,
  output logic [WIDTH-1:0] out_1_data,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  chan_e sel;
  logic  full_0;
  logic  full_1;
  logic  empty_0;
  logic  empty_1;
  logic  accept;
  logic  push_0;
  logic  push_1;

  assign sel = chan_e'(in_select);

  // in_ready looks only at the selected channel, never at in_valid.
  assign in_ready = (sel == CH_1) ? !full_1 : !full_0;
  assign accept   = in_valid && in_ready;
  assign push_0   = accept && (sel == CH_0);
  assign push_1   = accept && (sel == CH_1);

  assign out_0_valid = !empty_0;
  assign out_1_valid = !empty_1;

  demux_chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_data(in_data),
    .push     (push_0),
    .pop      (out_0_ready),
    .head_data(out_0_data),
    .full     (full_0),
    .empty    (empty_0)
  );

  demux_chan_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo_1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_data(in_data),
    .push     (push_1),
    .pop      (out_1_ready),
    .head_data(out_1_data),
    .full     (full_1),
    .empty    (empty_1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_0 <= '0;
      cnt_1 <= '0;
    end else begin
      if (push_0) begin
        cnt_0 <= cnt_0 + CNT_W'(1);
      end
      if (push_1) begin
        cnt_1 <= cnt_1 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_demux_1_to_2_buffered.sv
// Bench for demux_1_to_2_buffered: queue-based channel model checked every cycle,
// plus directed literal checks from the test plan.
module tb_demux_1_to_2_buffered;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_select = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_0_data;
  logic             out_0_valid;
  logic             out_0_ready = 1'b0;
  logic [WIDTH-1:0] out_1_data;
  logic             out_1_valid;
  logic             out_1_ready = 1'b0;
  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  int vectors = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];
  int               m_cnt_0 = 0;
  int               m_cnt_1 = 0;

  always #5 clk = ~clk;

  demux_1_to_2_buffered #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_select  (in_select),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_0_data (out_0_data),
    .out_0_valid(out_0_valid),
    .out_0_ready(out_0_ready),
    .out_1_data (out_1_data),
    .out_1_valid(out_1_valid),
    .out_1_ready(out_1_ready),
    .cnt_0      (cnt_0),
    .cnt_1      (cnt_1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, waits for the edge, returns 1 time unit after it.
  task automatic applyStimulus(input logic v, input logic sel, input logic [WIDTH-1:0] d,
                               input logic r0, input logic r1);
    in_valid    = v;
    in_select   = sel;
    in_data     = d;
    out_0_ready = r0;
    out_1_ready = r1;
    @(posedge clk);
    #1;
  endtask

  // Channel model: each channel is a bounded queue; counters count accepts modulo 2^CNT_W.
  always @(posedge clk) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_cnt_0 = 0;
      m_cnt_1 = 0;
    end else begin
      bit acc0, acc1, pop0, pop1;
      acc0 = in_valid && !in_select && (q0.size() < DEPTH);
      acc1 = in_valid && in_select && (q1.size() < DEPTH);
      pop0 = out_0_ready && (q0.size() > 0);
      pop1 = out_1_ready && (q1.size() > 0);
      if (pop0) void'(q0.pop_front());
      if (pop1) void'(q1.pop_front());
      if (acc0) begin
        q0.push_back(in_data);
        m_cnt_0 = (m_cnt_0 + 1) % (1 << CNT_W);
      end
      if (acc1) begin
        q1.push_back(in_data);
        m_cnt_1 = (m_cnt_1 + 1) % (1 << CNT_W);
      end
    end
  end

  always @(negedge clk) begin
    logic [WIDTH-1:0] e0, e1;
    e0 = (q0.size() > 0) ? q0[0] : '0;
    e1 = (q1.size() > 0) ? q1[0] : '0;
    checkOutput("model in_ready", 32'(in_ready),
                32'((in_select ? q1.size() : q0.size()) < DEPTH));
    checkOutput("model out_0_valid", 32'(out_0_valid), 32'(q0.size() > 0));
    checkOutput("model out_1_valid", 32'(out_1_valid), 32'(q1.size() > 0));
    checkOutput("model out_0_data", 32'(out_0_data), 32'(e0));
    checkOutput("model out_1_data", 32'(out_1_data), 32'(e1));
    checkOutput("model cnt_0", 32'(cnt_0), 32'(m_cnt_0));
    checkOutput("model cnt_1", 32'(cnt_1), 32'(m_cnt_1));
  end

  initial begin
    // Reset and idle.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset out_0_valid", 32'(out_0_valid), 32'd0);
    checkOutput("reset out_1_valid", 32'(out_1_valid), 32'd0);
    checkOutput("reset out_0_data", 32'(out_0_data), 32'd0);
    checkOutput("reset out_1_data", 32'(out_1_data), 32'd0);
    checkOutput("reset cnt_0", 32'(cnt_0), 32'd0);
    checkOutput("reset cnt_1", 32'(cnt_1), 32'd0);
    rst_n = 1'b1;

    // Simple steer.
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    checkOutput("steer out_0_data", 32'(out_0_data), 32'hA5);
    checkOutput("steer out_0_valid", 32'(out_0_valid), 32'd1);
    checkOutput("steer cnt_0", 32'(cnt_0), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    checkOutput("steer out_1_data", 32'(out_1_data), 32'h3C);
    checkOutput("steer out_0 drained", 32'(out_0_valid), 32'd0);
    checkOutput("steer cnt_1", 32'(cnt_1), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // Backpressure isolation on channel 0.
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    checkOutput("bp ready after 1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
    checkOutput("bp ready after 2", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
    checkOutput("bp head stable", 32'(out_0_data), 32'h11);
    checkOutput("bp cnt_0", 32'(cnt_0), 32'd3);
    in_select = 1'b1;
    #1;
    checkOutput("bp ready sel1", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    checkOutput("bp out_1_data", 32'(out_1_data), 32'h44);
    checkOutput("bp cnt_1", 32'(cnt_1), 32'd2);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    checkOutput("bp head still", 32'(out_0_data), 32'h11);

    // Full with simultaneous pop: first pop cycle must not accept.
    in_valid = 1'b1; in_select = 1'b0; in_data = 8'h55; out_0_ready = 1'b1;
    #1;
    checkOutput("full ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    checkOutput("full pop head", 32'(out_0_data), 32'h22);
    checkOutput("full no accept", 32'(cnt_0), 32'd3);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1, 1'b1);
    checkOutput("full accept head", 32'(out_0_data), 32'h55);
    checkOutput("full accept cnt", 32'(cnt_0), 32'd4);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("full drained", 32'(out_0_valid), 32'd0);

    // Select toggling while idle has no effect.
    applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'hEF, 1'b1, 1'b1);
    checkOutput("idle cnt_0", 32'(cnt_0), 32'd4);
    checkOutput("idle cnt_1", 32'(cnt_1), 32'd2);

    // Reset mid-operation discards buffered beats.
    applyStimulus(1'b1, 1'b0, 8'h66, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("pre-reset out_0_valid", 32'(out_0_valid), 32'd1);
    checkOutput("pre-reset out_1_valid", 32'(out_1_valid), 32'd1);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    rst_n = 1'b1;
    checkOutput("midreset out_0_valid", 32'(out_0_valid), 32'd0);
    checkOutput("midreset out_1_valid", 32'(out_1_valid), 32'd0);
    checkOutput("midreset cnt_0", 32'(cnt_0), 32'd0);
    checkOutput("midreset cnt_1", 32'(cnt_1), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("discard out_0_data", 32'(out_0_data), 32'd0);
    checkOutput("discard out_1_valid", 32'(out_1_valid), 32'd0);

    // Counter wrap: 17 beats to channel 1 with a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b1, WIDTH'(8'h80 + i), 1'b1, 1'b1);
    end
    checkOutput("wrap cnt_1", 32'(cnt_1), 32'd1);
    checkOutput("wrap cnt_0", 32'(cnt_0), 32'd0);

    // Mixed traffic with intermittent stalls on both channels.
    for (int i = 0; i < 24; i++) begin
      logic [4:0] pat;
      pat = 5'(i * 7 + 3);
      applyStimulus(pat[0] | pat[3], pat[1], WIDTH'(8'h40 + i), pat[2] | pat[4], pat[3] | pat[0]);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    end
    checkOutput("final out_0_valid", 32'(out_0_valid), 32'd0);
    checkOutput("final out_1_valid", 32'(out_1_valid), 32'd0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_1_to_2_buffered.md
# demux_1_to_2_buffered

Routes one input data stream to one of two output channels under a per-beat select bit. It is the receiving-end counterpart of the team's 2-to-1 multiplexer, which merges two sources onto one line. Each output channel has its own small FIFO and valid/ready handshake, so a stalled consumer on one channel never corrupts data bound for the other. Per-channel beat counters support debug and the bench scoreboard.

## Interface
Parameters:
- WIDTH, 8, data width of every stream
- DEPTH, 2, entries per channel FIFO; power of two, at least 2
- CNT_W, 16, width of the per-channel accepted-beat counters

Ports (clock and reset first):
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset; synchronous and active-low
- in_data  in  WIDTH  input beat
- in_select  in  1  destination channel: 0 sends to channel 0, 1 sends to channel 1
- in_valid  in  1  input beat present
- in_ready  out  1  input beat accepted this cycle when in_valid is also high
- out_0_data  out  WIDTH  channel 0 head data
- out_0_valid  out  1  channel 0 head valid
- out_0_ready  in  1  channel 0 consumer ready
- out_1_data  out  WIDTH  channel 1 head data
- out_1_valid  out  1  channel 1 head valid
- out_1_ready  in  1  channel 1 consumer ready
- cnt_0  out  CNT_W  beats accepted into channel 0
- cnt_1  out  CNT_W  beats accepted into channel 1

## Operation
- Push rule: an input beat is accepted when in_valid is high and in_ready is high. It is written into the FIFO of channel in_select.
- in_ready is combinational: it equals the not-full flag of the FIFO that in_select points to. It does not depend on the other channel or on in_valid.
- Pop rule: channel k pops when out_k_valid is high and out_k_ready is high.
- out_k_valid is high whenever FIFO k is not empty. out_k_data is the FIFO k head and stays stable while out_k_valid is high and out_k_ready is low.
- Ordering: beats within one channel leave in arrival order. No ordering is defined between channels.
- Each FIFO keeps its own write pointer and read pointer (log2(DEPTH) bits each, wrapping modulo DEPTH) plus an occupancy count from 0 to DEPTH.
- Full FIFO: a full FIFO refuses a push even if it pops in the same cycle (no pass-through when full).
- Push and pop together on a non-full, non-empty FIFO: both happen, and occupancy is unchanged.
- Push into an empty FIFO: the beat becomes visible on the next cycle. It does not pass through in the same cycle.
- Counters: cnt_k increments by 1 on each accepted beat to channel k. It wraps from 2^CNT_W−1 to 0 and does not saturate.
- in_select is sampled only on the accept cycle. Changing it while in_valid is low has no effect.

## Timing
- Latency from input to output is 1 cycle: a beat accepted at edge N is presented on out_k at edge N+1 if FIFO k was empty.
- Throughput per channel is 1 beat per cycle when the consumer holds ready high. The input sustains 1 beat per cycle while the selected FIFO is not full.
- Reset takes effect at a rising edge with rst_n low:
  - both FIFOs become empty, pointers go to 0, counters go to 0
  - out_0_valid = out_1_valid = 0
  - out_0_data = out_1_data = 0
  - in_ready = 1 after reset
- Reset asserted mid-transfer discards all buffered beats. No handshake completes on a reset edge.
- Stored data registers do not need reset. out_k_data must still read 0 while FIFO k is empty after reset, achieved by gating with valid or by resetting the storage.

## Structure
- Sub-module demux_chan_fifo holds WIDTH, DEPTH, the storage, pointers, occupancy, and the full and empty flags. It is instantiated twice, once per channel.
- The top level holds the select steering, in_ready generation, and the counters.
- Shared package mux_pkg holds the channel encodings CH_0 = 1'b0 and CH_1 = 1'b1. The 2-to-1 mux and this block both use it.
- The block is fully synchronous with no latches. The only combinational input-to-output path is in_select to in_ready.

## Test plan
- Reset and idle: hold rst_n low for 2 cycles, then release. Required: in_ready=1, both valids 0, both data 0, cnt_0=cnt_1=0.
- Simple steer: send in_data=8'hA5 with select 0, then 8'h3C with select 1, both consumers ready. Required: out_0 shows A5 one cycle after its accept; out_1 shows 3C one cycle after its accept; cnt_0=1, cnt_1=1.
- Backpressure isolation: hold out_0_ready=0 and push 3 beats to channel 0 (DEPTH=2). Required:
  - in_ready drops after 2 beats while select=0
  - switching select to 1 raises in_ready and channel 1 flows
  - out_0_data holds the first beat stable
- Full with simultaneous pop: fill channel 0, then set out_0_ready=1 with in_valid=1 and select=0. Required: no accept on the first pop cycle; accept on the next cycle; FIFO order preserved.
- Counter wrap: with CNT_W=4, send 17 beats to channel 1. Required: cnt_1 reads 1.
- Reset mid-operation: both FIFOs hold 1 beat, then rst_n goes low for 1 cycle. Required: both valids 0 and counters 0 on the next cycle; the discarded beats never appear on the outputs.
